// File: rtl/alu_bitscan_pkg.sv
// Shared encodings for the bit-scan unit: operation modes and FSM states.
package alu_bitscan_pkg;

  typedef enum logic [1:0] {
    BS_CLZ = 2'b00,
    BS_CLO = 2'b01,
    BS_CTZ = 2'b10,
    BS_POP = 2'b11
  } bs_mode_e;

  typedef enum logic [1:0] {
    BS_IDLE = 2'b00,
    BS_SCAN = 2'b01,
    BS_DONE = 2'b10
  } bs_state_e;

endpackage

// File: rtl/alu_bitscan_chunk.sv
// Combinational per-chunk analysis: nonzero flag, leading-zero count and popcount.
module alu_bitscan_chunk #(
  parameter int STEP = 4,
  parameter int CW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] chunk_i,
  output logic            nz_o,
  output logic [CW-1:0]   lz_o,
  output logic [CW-1:0]   pc_o
);

  always_comb begin
    nz_o = |chunk_i;
    lz_o = CW'(STEP);
    pc_o = '0;
    // Ascending walk: the highest set bit is the last one to overwrite lz_o.
    for (int i = 0; i < STEP; i++) begin
      pc_o = pc_o + CW'(chunk_i[i]);
      if (chunk_i[i]) lz_o = CW'(STEP - 1 - i);
    end
  end

endmodule

// File: rtl/alu_bitscan.sv
// Multi-cycle CLZ/CLO/CTZ/POPCNT unit scanning STEP bits per cycle, MSB chunk first,
// with the valid/ready/end handshake shared by the other multi-cycle EX units.
module alu_bitscan
  import alu_bitscan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] opdata_i,
  input  logic             flush_i,
  input  logic             end_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [RES_W-1:0] result_o
);

  localparam int NCH = WIDTH / STEP;
  localparam int AW  = $clog2(WIDTH + 1);
  localparam int CW  = $clog2(STEP + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  bs_state_e        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             pop_q, pop_d;

  logic [WIDTH-1:0] norm;
  logic [STEP-1:0]  chunk;
  logic             ch_nz;
  logic [CW-1:0]    ch_lz, ch_pc;
  logic             accept, last;

  // CLO and CTZ are folded into "count leading zeros" at accept time.
  always_comb begin
    norm = opdata_i;
    case (mode_i)
      BS_CLO:  norm = ~opdata_i;
      BS_CTZ:  for (int i = 0; i < WIDTH; i++) norm[i] = opdata_i[WIDTH-1-i];
      default: norm = opdata_i;
    endcase
  end

  // The operand shifts left after each chunk, so the current chunk is always the top STEP bits.
  assign chunk = op_q[WIDTH-1 -: STEP];

  alu_bitscan_chunk #(
    .STEP (STEP),
    .CW   (CW)
  ) u_chunk (
    .chunk_i (chunk),
    .nz_o    (ch_nz),
    .lz_o    (ch_lz),
    .pc_o    (ch_pc)
  );

  assign accept = valid_i && !flush_i &&
                  ((state_q == BS_IDLE) || ((state_q == BS_DONE) && end_i));
  assign last   = (idx_q == IW'(NCH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    op_d    = op_q;
    pop_d   = pop_q;
    if (accept) begin
      state_d = BS_SCAN;
      idx_d   = '0;
      acc_d   = '0;
      op_d    = norm;
      pop_d   = (mode_i == BS_POP);
    end else begin
      case (state_q)
        BS_SCAN: begin
          if (flush_i) begin
            state_d = BS_IDLE;
            acc_d   = '0;
          end else if (pop_q) begin
            acc_d = acc_q + AW'(ch_pc);
            if (last) state_d = BS_DONE;
            else begin
              idx_d = idx_q + IW'(1);
              op_d  = op_q << STEP;
            end
          end else if (ch_nz) begin
            acc_d   = acc_q + AW'(ch_lz);
            state_d = BS_DONE;
          end else begin
            acc_d = acc_q + AW'(STEP);
            if (last) state_d = BS_DONE;
            else begin
              idx_d = idx_q + IW'(1);
              op_d  = op_q << STEP;
            end
          end
        end
        BS_DONE: begin
          if (flush_i) begin
            state_d = BS_IDLE;
            acc_d   = '0;
          end else if (end_i) begin
            state_d = BS_IDLE;
          end
        end
        BS_IDLE: state_d = BS_IDLE;
        default: state_d = BS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BS_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      pop_q   <= pop_d;
    end
  end

  assign busy_o   = (state_q == BS_SCAN);
  assign ready_o  = (state_q == BS_DONE);
  assign result_o = RES_W'(acc_q);

endmodule

// File: tb/tb_alu_bitscan.sv
// Scoreboard bench for alu_bitscan: directed vectors on a 32/4 instance plus a
// lockstep sweep over 64/8, 16/1 and 32/32 instances checked against a bit-loop model.
module tb_alu_bitscan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int res;
    int lat;
    int t0;
  } exp_t;

  exp_t qa[$];
  exp_t sq[3][$];

  // Main instance, WIDTH=32 STEP=4
  logic        a_valid = 1'b0, a_flush = 1'b0, a_end = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [31:0] a_op = '0;
  logic        a_busy, a_rdy;
  logic [31:0] a_res;

  alu_bitscan #(.WIDTH(32), .STEP(4), .RES_W(32)) dut_a (
    .clk(clk), .rst(rst), .valid_i(a_valid), .mode_i(a_mode), .opdata_i(a_op),
    .flush_i(a_flush), .end_i(a_end), .busy_o(a_busy), .ready_o(a_rdy), .result_o(a_res));

  // Sweep instances, driven in lockstep
  logic        s_valid = 1'b0, s_flush = 1'b0, s_end = 1'b0;
  logic [1:0]  s_mode = 2'b00;
  logic [63:0] s_op = '0;
  logic [2:0]  s_busy, s_rdy;
  logic [7:0]  b_res;
  logic [4:0]  c_res;
  logic [5:0]  d_res;

  alu_bitscan #(.WIDTH(64), .STEP(8), .RES_W(8)) dut_b (
    .clk(clk), .rst(rst), .valid_i(s_valid), .mode_i(s_mode), .opdata_i(s_op),
    .flush_i(s_flush), .end_i(s_end), .busy_o(s_busy[0]), .ready_o(s_rdy[0]), .result_o(b_res));

  alu_bitscan #(.WIDTH(16), .STEP(1), .RES_W(5)) dut_c (
    .clk(clk), .rst(rst), .valid_i(s_valid), .mode_i(s_mode), .opdata_i(s_op[15:0]),
    .flush_i(s_flush), .end_i(s_end), .busy_o(s_busy[1]), .ready_o(s_rdy[1]), .result_o(c_res));

  alu_bitscan #(.WIDTH(32), .STEP(32), .RES_W(6)) dut_d (
    .clk(clk), .rst(rst), .valid_i(s_valid), .mode_i(s_mode), .opdata_i(s_op[31:0]),
    .flush_i(s_flush), .end_i(s_end), .busy_o(s_busy[2]), .ready_o(s_rdy[2]), .result_o(d_res));

  int sw_w[3]  = '{64, 16, 32};
  int sw_st[3] = '{8, 1, 32};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: straightforward bit walk, latency from position of the first target bit.
  function automatic void model(input int w, input int st, input int m, input logic [63:0] op,
                                output int res, output int lat);
    int  cnt;
    bit  stop;
    int  b;
    logic skipv;
    cnt  = 0;
    stop = 0;
    if (m == 3) begin
      for (int i = 0; i < w; i++) cnt += int'(op[i]);
      res = cnt;
      lat = w / st;
      return;
    end
    skipv = (m == 1);
    for (int i = 0; i < w; i++) begin
      b = (m == 2) ? i : (w - 1 - i);
      if (!stop && (op[b] == skipv)) cnt++;
      else stop = 1;
    end
    res = cnt;
    lat = (cnt == w) ? (w / st) : (cnt / st + 1);
  endfunction

  // Monitor for the main instance
  logic a_prev = 1'b0;
  exp_t ea;
  always @(negedge clk) begin
    if (a_rdy && !a_prev) begin
      if (qa.size() == 0) chk("a_spurious_ready", 64'(a_rdy), 64'd0);
      else begin
        ea = qa.pop_front();
        chk("a_result", 64'(a_res), 64'(ea.res));
        chk("a_latency", 64'(cyc - ea.t0), 64'(ea.lat));
      end
    end
    a_prev = a_rdy;
  end

  // Monitor for the sweep instances
  logic [2:0]  s_prev = 3'b000;
  exp_t        es;
  logic [63:0] s_act;
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (s_rdy[j] && !s_prev[j]) begin
        s_act = (j == 0) ? 64'(b_res) : (j == 1) ? 64'(c_res) : 64'(d_res);
        if (sq[j].size() == 0) chk($sformatf("sw%0d_spurious_ready", j), 64'(s_rdy[j]), 64'd0);
        else begin
          es = sq[j].pop_front();
          chk($sformatf("sw%0d_result", j), s_act, 64'(es.res));
          chk($sformatf("sw%0d_latency", j), 64'(cyc - es.t0), 64'(es.lat));
        end
      end
    end
    s_prev = s_rdy;
  end

  task automatic issue_a(input logic [1:0] m, input logic [31:0] op, input bit with_end,
                         input bit push, input int res, input int lat);
    @(negedge clk);
    a_valid = 1'b1; a_mode = m; a_op = op; a_end = with_end;
    @(posedge clk);
    #1;
    if (push) qa.push_back('{res, lat, cyc});
    a_valid = 1'b0; a_end = 1'b0;
  endtask

  task automatic wait_a();
    int n;
    n = 0;
    @(negedge clk);
    while (!a_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_ready_timeout", 64'(a_rdy), 64'd1);
  endtask

  task automatic take_a();
    wait_a();
    a_end = 1'b1;
    @(posedge clk);
    #1 a_end = 1'b0;
  endtask

  logic [63:0] vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, l, n;
    vecs = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000,
             64'h0000_0001_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF,
             64'h0000_0000_0000_8000, 64'h0, 64'h0};
    vecs[8] = {$urandom, $urandom};
    vecs[9] = {$urandom, $urandom};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(a_busy), 64'd0);
    chk("reset_ready", 64'(a_rdy), 64'd0);
    chk("reset_result", 64'(a_res), 64'd0);
    rst = 1'b0;

    // CLZ with held result
    issue_a(2'b00, 32'h0001_0000, 1'b0, 1'b1, 15, 4);
    wait_a();
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", 64'(a_res), 64'd15);
      chk("hold_ready", 64'(a_rdy), 64'd1);
    end

    // Back-to-back issue from DONE
    issue_a(2'b00, 32'h8000_0000, 1'b1, 1'b1, 0, 1);
    @(negedge clk);
    chk("b2b_ready_drop", 64'(a_rdy), 64'd0);
    take_a();

    issue_a(2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 32, 8); take_a();
    issue_a(2'b10, 32'h0000_0000, 1'b0, 1'b1, 32, 8); take_a();
    issue_a(2'b00, 32'h0000_0000, 1'b0, 1'b1, 32, 8); take_a();
    issue_a(2'b10, 32'h0000_0008, 1'b0, 1'b1, 3, 1);  take_a();
    @(negedge clk);
    chk("idle_result_kept", 64'(a_res), 64'd3);
    chk("idle_ready", 64'(a_rdy), 64'd0);
    chk("idle_busy", 64'(a_busy), 64'd0);

    issue_a(2'b11, 32'hA5A5_A5A5, 1'b0, 1'b1, 16, 8); take_a();
    issue_a(2'b11, 32'h0000_0000, 1'b0, 1'b1, 0, 8);  take_a();

    // valid_i during SCAN is ignored
    issue_a(2'b00, 32'h0000_0001, 1'b0, 1'b1, 31, 8);
    @(negedge clk);
    a_valid = 1'b1; a_mode = 2'b11; a_op = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 a_valid = 1'b0;
    take_a();

    // Flush on the third scan cycle
    issue_a(2'b00, 32'h0000_0001, 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", 64'(a_busy), 64'd1);
    a_flush = 1'b1;
    @(posedge clk);
    #1 a_flush = 1'b0;
    chk("flush_busy", 64'(a_busy), 64'd0);
    chk("flush_ready", 64'(a_rdy), 64'd0);
    chk("flush_result", 64'(a_res), 64'd0);
    repeat (10) @(negedge clk);
    chk("flush_no_ready", 64'(a_rdy), 64'd0);

    // Flush in IDLE blocks a same-cycle valid
    @(negedge clk);
    a_flush = 1'b1; a_valid = 1'b1; a_mode = 2'b00; a_op = 32'h1;
    @(posedge clk);
    #1 a_flush = 1'b0; a_valid = 1'b0;
    chk("idle_flush_busy", 64'(a_busy), 64'd0);
    issue_a(2'b00, 32'h00F0_0000, 1'b0, 1'b1, 8, 3); take_a();

    // Reset while in DONE
    issue_a(2'b00, 32'h0000_0100, 1'b0, 1'b1, 23, 6);
    wait_a();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_done_busy", 64'(a_busy), 64'd0);
    chk("rst_done_ready", 64'(a_rdy), 64'd0);
    chk("rst_done_result", 64'(a_res), 64'd0);

    // Parameter sweep
    for (int v = 0; v < 10; v++) begin
      for (int m = 0; m < 4; m++) begin
        @(negedge clk);
        s_valid = 1'b1; s_mode = 2'(m); s_op = vecs[v];
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
          model(sw_w[j], sw_st[j], m, vecs[v], r, l);
          sq[j].push_back('{r, l, cyc});
        end
        s_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (s_rdy != 3'b111 && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("sweep_ready_timeout", 64'(s_rdy), 64'd7);
        s_end = 1'b1;
        @(posedge clk);
        #1 s_end = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    chk("a_pending", 64'(qa.size()), 64'd0);
    for (int j = 0; j < 3; j++) chk($sformatf("sw%0d_pending", j), 64'(sq[j].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
